// File: rtl/dz_tx_scanner.sv
// dz_tx_scanner: DZ11 transmit scanner and scheduler.
// Walks the 8 lines round-robin, one line every SCAN_DIV clocks, looking for a
// line that is enabled in TCR and whose UART transmitter is empty. It offers that
// line to the bus side as trdy/tline. The next TDR write then becomes a one-clock,
// one-hot load strobe into that line's UART.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   csrMSE, csrTIE      CSR master scan enable, transmit interrupt enable
//   regTCR              per-line transmit enable
//   uartTXEMPTY         per-line UART transmit buffer empty
//   tdrWrite, tdrData   bus write strobe to TDR and the character written
//   trdy, tline         CSR TRDY / TLINE
//   uartTXLOAD          one-hot, one-clock load strobe to UART n
//   uartTXDATA          character presented to the UARTs, held between loads
//   txIntr              transmit interrupt request (level)
// All outputs are registered.

module dz_tx_scanner #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       csrMSE,
  input  logic       csrTIE,
  input  logic [7:0] regTCR,
  input  logic [7:0] uartTXEMPTY,
  input  logic       tdrWrite,
  input  logic [7:0] tdrData,
  output logic       trdy,
  output logic [2:0] tline,
  output logic [7:0] uartTXLOAD,
  output logic [7:0] uartTXDATA,
  output logic       txIntr
);

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, SCAN, READY, LOAD} state_t;

  state_t     state, state_nx;
  logic [2:0] ptr, ptr_nx;
  logic [7:0] div, div_nx;
  logic       trdy_nx;
  logic [2:0] tline_nx;
  logic [7:0] load_nx;
  logic [7:0] data_nx;
  logic       intr_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 3'd0;
      div        <= 8'd0;
      trdy       <= 1'b0;
      tline      <= 3'd0;
      uartTXLOAD <= 8'd0;
      uartTXDATA <= 8'd0;
      txIntr     <= 1'b0;
    end else begin
      state      <= state_nx;
      ptr        <= ptr_nx;
      div        <= div_nx;
      trdy       <= trdy_nx;
      tline      <= tline_nx;
      uartTXLOAD <= load_nx;
      uartTXDATA <= data_nx;
      txIntr     <= intr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    div_nx   = div;
    trdy_nx  = trdy;
    tline_nx = tline;
    load_nx  = 8'd0;        // the load strobe only ever lasts one clock
    data_nx  = uartTXDATA;  // character is held until the next load
    // Interrupt is a registered copy of trdy gated by TIE, one clock behind trdy.
    intr_nx  = trdy & csrTIE;

    if (!csrMSE) begin
      // Scanning disabled: drop any offered line. A load strobe already on the
      // outputs still clears on its own because load_nx defaults to 0.
      state_nx = IDLE;
      trdy_nx  = 1'b0;
      ptr_nx   = 3'd0;
      div_nx   = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = SCAN;
          trdy_nx  = 1'b0;
          ptr_nx   = 3'd0;
          div_nx   = 8'd0;
        end

        SCAN: begin
          if (div == DIV_LAST) begin
            div_nx = 8'd0;
            if (regTCR[ptr] && uartTXEMPTY[ptr]) begin
              tline_nx = ptr;
              trdy_nx  = 1'b1;
              state_nx = READY;
            end else begin
              ptr_nx = ptr + 3'd1;
            end
          end else begin
            div_nx = div + 8'd1;
          end
        end

        READY: begin
          // A write in the same clock as a TCR clear still gets its character out.
          if (tdrWrite) begin
            data_nx  = tdrData;
            load_nx  = 8'd1 << tline;
            trdy_nx  = 1'b0;
            state_nx = LOAD;
          end else if (!regTCR[tline]) begin
            trdy_nx  = 1'b0;
            ptr_nx   = tline + 3'd1;
            div_nx   = 8'd0;
            state_nx = SCAN;
          end
        end

        LOAD: begin
          // Resume the search just past the line that was served (fairness).
          ptr_nx   = tline + 3'd1;
          div_nx   = 8'd0;
          state_nx = SCAN;
        end

        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dz_tx_scanner.sv
// Directed, self-checking bench for dz_tx_scanner with SCAN_DIV=4.
// Inputs are driven and outputs sampled 1 ns after each rising edge.

module tb_dz_tx_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       csrMSE;
  logic       csrTIE;
  logic [7:0] regTCR;
  logic [7:0] uartTXEMPTY;
  logic       tdrWrite;
  logic [7:0] tdrData;
  logic       trdy;
  logic [2:0] tline;
  logic [7:0] uartTXLOAD;
  logic [7:0] uartTXDATA;
  logic       txIntr;

  int n_cmp = 0;
  int n_bad = 0;

  dz_tx_scanner #(.SCAN_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .csrMSE      (csrMSE),
    .csrTIE      (csrTIE),
    .regTCR      (regTCR),
    .uartTXEMPTY (uartTXEMPTY),
    .tdrWrite    (tdrWrite),
    .tdrData     (tdrData),
    .trdy        (trdy),
    .tline       (tline),
    .uartTXLOAD  (uartTXLOAD),
    .uartTXDATA  (uartTXDATA),
    .txIntr      (txIntr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until trdy rises; n = clocks elapsed since the last tick before the call.
  task automatic wait_trdy(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!trdy && n < limit);
    if (!trdy) chk("trdy_timeout", 32'(trdy), 32'd1);
  endtask

  // Issue one TDR write while READY and check the resulting load clock.
  task automatic write_tdr(input string tag, input logic [7:0] d, input logic [7:0] exp_load);
    tdrWrite = 1'b1;
    tdrData  = d;
    tick();
    tdrWrite = 1'b0;
    chk({tag, "_load"}, 32'(uartTXLOAD), 32'(exp_load));
    chk({tag, "_data"}, 32'(uartTXDATA), 32'(d));
    chk({tag, "_trdy"}, 32'(trdy), 32'd0);
  endtask

  logic [2:0] rr_line [4] = '{3'd0, 3'd7, 3'd0, 3'd7};
  int         rr_lat  [4] = '{4, 28, 4, 28};
  logic [7:0] rr_load [4] = '{8'h01, 8'h80, 8'h01, 8'h80};

  initial begin
    int n;
    int stray;

    rst = 1'b1; csrMSE = 1'b0; csrTIE = 1'b1; regTCR = 8'h00;
    uartTXEMPTY = 8'hFF; tdrWrite = 1'b0; tdrData = 8'h00;
    tick(); tick();
    chk("rst_trdy",  32'(trdy),       32'd0);
    chk("rst_tline", 32'(tline),      32'd0);
    chk("rst_load",  32'(uartTXLOAD), 32'd0);
    chk("rst_data",  32'(uartTXDATA), 32'd0);
    chk("rst_intr",  32'(txIntr),     32'd0);
    rst = 1'b0;
    tick();

    // Basic find: line 3 is the 4th examination -> 16 clocks after SCAN entry.
    regTCR = 8'h08; csrMSE = 1'b1;
    tick();                              // SCAN entry edge
    for (int i = 0; i < 15; i++) tick();
    chk("find_early_trdy", 32'(trdy), 32'd0);
    tick();
    chk("find_trdy",  32'(trdy),   32'd1);
    chk("find_tline", 32'(tline),  32'd3);
    chk("find_intr0", 32'(txIntr), 32'd0);
    tick();
    chk("find_intr1", 32'(txIntr), 32'd1);
    chk("find_hold",  32'(tline),  32'd3);

    // Load on line 3, then the scan must resume at line 4.
    write_tdr("load3", 8'h41, 8'h08);
    regTCR = 8'h18;
    tick();
    chk("load3_end",  32'(uartTXLOAD), 32'd0);
    chk("load3_held", 32'(uartTXDATA), 32'h41);
    wait_trdy(100, n);
    chk("resume_lat",   32'(n),     32'd4);
    chk("resume_tline", 32'(tline), 32'd4);

    // Asynchronous reset in the middle of READY.
    csrMSE = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_trdy",  32'(trdy),       32'd0);
    chk("arst_tline", 32'(tline),      32'd0);
    chk("arst_load",  32'(uartTXLOAD), 32'd0);
    chk("arst_data",  32'(uartTXDATA), 32'd0);
    chk("arst_intr",  32'(txIntr),     32'd0);
    #1;
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (trdy || txIntr || (uartTXLOAD != 8'd0)) stray++;
    end
    chk("mse_off_quiet", 32'(stray), 32'd0);

    // Round-robin with wrap: lines 0 and 7 only.
    regTCR = 8'h81; csrMSE = 1'b1;
    tick();                              // SCAN entry edge
    for (int k = 0; k < 4; k++) begin
      wait_trdy(100, n);
      chk($sformatf("rr%0d_lat", k),   32'(n),     32'(rr_lat[k]));
      chk($sformatf("rr%0d_tline", k), 32'(tline), 32'(rr_line[k]));
      write_tdr($sformatf("rr%0d", k), 8'(8'h60 + k), rr_load[k]);
      if (k == 3) regTCR = 8'h20;
      tick();                            // LOAD -> SCAN
      chk($sformatf("rr%0d_end", k), 32'(uartTXLOAD), 32'd0);
    end

    // TCR drop on line 5: no load, search continues at line 6.
    wait_trdy(100, n);
    chk("drop_lat",   32'(n),     32'd24);
    chk("drop_tline", 32'(tline), 32'd5);
    regTCR = 8'h40;
    tick();
    chk("drop_trdy", 32'(trdy),       32'd0);
    chk("drop_load", 32'(uartTXLOAD), 32'd0);
    wait_trdy(100, n);
    chk("drop_next_lat",   32'(n),     32'd4);
    chk("drop_next_tline", 32'(tline), 32'd6);
    write_tdr("line6", 8'h33, 8'h40);
    regTCR = 8'h20;
    tick();

    // TCR clear coincident with a write: the write wins.
    wait_trdy(100, n);
    chk("coin_lat",   32'(n),     32'd28);
    chk("coin_tline", 32'(tline), 32'd5);
    regTCR = 8'h00;
    write_tdr("coin", 8'h55, 8'h20);
    regTCR = 8'h20;
    tick();

    // MSE cleared while READY: back to IDLE, nothing loaded.
    wait_trdy(100, n);
    chk("abort_lat",   32'(n),     32'd32);
    chk("abort_tline", 32'(tline), 32'd5);
    csrMSE = 1'b0;
    tick();
    chk("abort_trdy", 32'(trdy),       32'd0);
    chk("abort_load", 32'(uartTXLOAD), 32'd0);
    tick();
    chk("abort_intr",  32'(txIntr),     32'd0);
    chk("abort_load2", 32'(uartTXLOAD), 32'd0);

    // Stray writes in IDLE and in SCAN are ignored.
    tdrWrite = 1'b1; tdrData = 8'h99;
    tick();
    tdrWrite = 1'b0;
    chk("idle_wr_load", 32'(uartTXLOAD), 32'd0);
    chk("idle_wr_data", 32'(uartTXDATA), 32'h55);
    regTCR = 8'h00; csrMSE = 1'b1;
    tick(); tick(); tick();
    tdrWrite = 1'b1; tdrData = 8'hAA;
    tick();
    tdrWrite = 1'b0;
    chk("scan_wr_load", 32'(uartTXLOAD), 32'd0);
    chk("scan_wr_data", 32'(uartTXDATA), 32'h55);
    chk("scan_wr_trdy", 32'(trdy),       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
